id_ex_alu_issue: RTL
====================

Name: id_ex_alu_issue

Overview:
- ID/EX boundary block: decodes the ALUOp/funct fields into the 4-bit EX ALU op code and selects operand B (rs2 or immediate).
- Registers everything into a single-entry pipeline register with a valid/ready handshake toward EX.
- Producer side of the EX ALU interface. Supplies a, b and op to the ALU. Supports flush and counts illegal ALU encodings.

Parameters:
- XLEN, 32, operand/immediate width
- CNT_W, 8, width of saturating illegal-op counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  block can accept this cycle
- aluop  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- funct3  in  3  instruction funct3
- funct7_5  in  1  instruction bit 30
- alu_src  in  1  1: operand B = imm, 0: operand B = rs2_data
- rs1_data  in  XLEN  register source 1
- rs2_data  in  XLEN  register source 2
- imm  in  XLEN  sign-extended immediate
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  EX register holds a valid instruction
- out_ready  in  1  EX consumes this cycle
- ex_a  out  XLEN  ALU operand a
- ex_b  out  XLEN  ALU operand b
- ex_op  out  4  ALU op: 0010 add, 0110 sub, 0000 and, 0001 or, 1111 illegal
- ex_branch  out  1  held instruction is a branch (EX uses ALU equality flag)
- ex_illegal  out  1  held instruction had an unsupported encoding
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, ex_a=0, ex_b=0, ex_op=0000, ex_branch=0, ex_illegal=0, illegal_cnt=0.
  - rst overrides every other input, including mid-transfer.
- in_ready = !flush && (!out_valid || out_ready). Combinational, no dependency on in_valid.
- Accept: fire = in_valid && in_ready.
  - On fire: ex_a<=rs1_data, ex_b<=(alu_src ? imm : rs2_data), ex_op<=decode, ex_branch<=(aluop==01), ex_illegal<=(decode==1111), out_valid<=1.
  - Latency: exactly 1 cycle from fire to out_valid.
- Drain: out_valid && out_ready && !fire gives out_valid<=0.
  - Data registers hold their last values; content is don't-care while out_valid=0.
- Simultaneous drain and accept (full, out_ready=1, in_valid=1): new instruction loads, out_valid stays 1. Full throughput, no bubble.
- Stall: out_valid=1, out_ready=0.
  - All ex_* outputs hold stable.
  - in_ready=0.
- Flush (highest priority after rst):
  - out_valid<=0.
  - The input offered in the same cycle is not accepted (in_ready=0) and is not counted.
  - Other registers hold.
- Decode:
  - aluop=00 gives 0010.
  - aluop=01 gives 0110.
  - aluop=10:
    - funct3=000 with funct7_5=0 gives 0010; with funct7_5=1 gives 0110.
    - funct3=111 gives 0000.
    - funct3=110 gives 0001.
    - Any other funct3 gives 1111.
  - aluop=11:
    - funct3=000 gives 0010; funct7_5 is ignored.
    - funct3=111 gives 0000.
    - funct3=110 gives 0001.
    - Any other funct3 gives 1111.
  - funct fields are ignored for aluop 00/01.
- illegal_cnt: increments by 1 on each fire with decode==1111. Saturates at 2^CNT_W-1 (no wrap). Cleared only by rst.
- Arithmetic: none in this block. Operands pass through unmodified at XLEN width.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, ex_op=0000, illegal_cnt=0, in_ready=1.
- R-type sub: aluop=10, funct3=000, funct7_5=1, rs1=0x0000000A, rs2=0x00000003, alu_src=0, in_valid=1 -> next cycle out_valid=1, ex_a=0x0A, ex_b=0x03, ex_op=0110.
- I-type or with stall: aluop=11, funct3=110, imm=0xFFFFFFF0, alu_src=1, out_ready=0 for 3 cycles:
  - ex_op=0001 and ex_b=0xFFFFFFF0 held stable all 3 cycles, in_ready=0.
  - out_ready=1 plus a new add on the same cycle -> back-to-back transfer, out_valid stays 1, new data next cycle.
- Branch: aluop=01, rs1=rs2=0x12345678 -> ex_op=0110, ex_branch=1, ex_b=0x12345678.
- Illegal: aluop=10, funct3=001, issued 300 times with CNT_W=8 -> every transfer has ex_op=1111 and ex_illegal=1; illegal_cnt saturates at 255.
- Flush collision: out_valid=1, then flush=1 with in_valid=1 (aluop=00) -> in_ready=0, next cycle out_valid=0, illegal_cnt unchanged. A reset asserted during a stall clears out_valid at the next edge.

Source files
------------

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes ALUOp/funct into the EX ALU op, selects operand B,
// and holds the result in a single-entry valid/ready pipeline register.
module id_ex_alu_issue #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             alu_src,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [3:0]       ex_op,
    output logic             ex_branch,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0]       OP_ADD  = 4'b0010;
    localparam logic [3:0]       OP_SUB  = 4'b0110;
    localparam logic [3:0]       OP_AND  = 4'b0000;
    localparam logic [3:0]       OP_OR   = 4'b0001;
    localparam logic [3:0]       OP_ILL  = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  ex_a_q, ex_a_d;
    logic [XLEN-1:0]  ex_b_q, ex_b_d;
    logic [3:0]       ex_op_q, ex_op_d;
    logic             ex_branch_q, ex_branch_d;
    logic             ex_illegal_q, ex_illegal_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic [3:0]       dec_op;
    logic             fire;

    always_comb begin
        dec_op = OP_ILL;
        case (aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  dec_op = funct7_5 ? OP_SUB : OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    default: dec_op = OP_ILL;
                endcase
            end
            default: begin
                // I-type: bit 30 belongs to the immediate, so no sub here
                case (funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    default: dec_op = OP_ILL;
                endcase
            end
        endcase
    end

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign fire     = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        ex_a_d        = ex_a_q;
        ex_b_d        = ex_b_q;
        ex_op_d       = ex_op_q;
        ex_branch_d   = ex_branch_q;
        ex_illegal_d  = ex_illegal_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d  = 1'b1;
            ex_a_d       = rs1_data;
            ex_b_d       = alu_src ? imm : rs2_data;
            ex_op_d      = dec_op;
            ex_branch_d  = (aluop == 2'b01);
            ex_illegal_d = (dec_op == OP_ILL);
            if ((dec_op == OP_ILL) && (illegal_cnt_q != CNT_MAX)) begin
                illegal_cnt_d = illegal_cnt_q + CNT_ONE;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_op_q       <= 4'b0000;
            ex_branch_q   <= 1'b0;
            ex_illegal_q  <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_op_q       <= ex_op_d;
            ex_branch_q   <= ex_branch_d;
            ex_illegal_q  <= ex_illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign ex_a        = ex_a_q;
    assign ex_b        = ex_b_q;
    assign ex_op       = ex_op_q;
    assign ex_branch   = ex_branch_q;
    assign ex_illegal  = ex_illegal_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule
